// File: rtl/vga_scaled_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_scaled_if
// Description : Bundle between the raster generator, its framebuffer read
//               port and the VGA pins.
//               master (raster generator):
//                 in  : en, fb_pixel[3*COLOR_W]   ({b,g,r}, 1 cycle after addr)
//                 out : fb_addr[ADDR_W], vga_r/g/b[COLOR_W],
//                       vga_hsync, vga_vsync, vblank, frame_start
//               slave : mirror image (framebuffer RAM + control + connector)
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_scaled_if #(
  parameter int COLOR_W = 1,
  parameter int ADDR_W  = 16
);
  logic                   en;
  logic [ADDR_W-1:0]      fb_addr;
  logic [3*COLOR_W-1:0]   fb_pixel;
  logic [COLOR_W-1:0]     vga_r;
  logic [COLOR_W-1:0]     vga_g;
  logic [COLOR_W-1:0]     vga_b;
  logic                   vga_hsync;
  logic                   vga_vsync;
  logic                   vblank;
  logic                   frame_start;

  modport master (
    input  en, fb_pixel,
    output fb_addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vblank, frame_start
  );

  modport slave (
    output en, fb_pixel,
    input  fb_addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vblank, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_scaled.sv
`default_nettype none
// ============================================================================
// Module      : vga_scaled
// Description : VGA raster generator that reads a low-resolution framebuffer
//               through a 1-cycle synchronous read port and replicates each
//               framebuffer pixel X_SCALE x Y_SCALE times on screen.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               bus  - vga_scaled_if.master (en, framebuffer port, VGA pins,
//                      vblank and frame_start strobes)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scaled #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int CLKS_PER_PIXEL  = 2,
  parameter int X_SCALE         = 3,
  parameter int Y_SCALE         = 3,
  parameter int FB_WIDTH        = 213,
  parameter int FB_HEIGHT       = 160,
  parameter int COLOR_W         = 1,
  parameter int ADDR_W          = 16,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  wire logic    clk,
  input  wire logic    rst,
  vga_scaled_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int XSW     = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
  localparam int YSW     = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;
  localparam int FXW     = $clog2(FB_WIDTH + 1);
  localparam int FYW     = $clog2(V_VISIBLE + 1);
  localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  // Timing and addressing state
  logic [DW-1:0]     div_q, div_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [XSW-1:0]    x_sub_q, x_sub_d;
  logic [FXW-1:0]    fb_x_q, fb_x_d;
  logic [YSW-1:0]    y_sub_q, y_sub_d;
  logic [FYW-1:0]    fb_y_q, fb_y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;

  // Pipeline stage 1 (flags of state T) and stage 2 (registered outputs)
  logic s1_hs_q, s1_vs_q, s1_infb_q, s1_en_q, s1_vb_q, s1_fs_q;
  logic [3*COLOR_W-1:0] rgb_q;
  logic hsync_q, vsync_q, vblank_q, fs_q;

  logic pix_tick, h_wrap, v_wrap, h_vis, v_vis, in_fb, hsync_raw, vsync_raw;

  assign pix_tick  = (div_q == DW'(CLKS_PER_PIXEL - 1));
  assign h_wrap    = pix_tick && (h_q == HW'(H_TOTAL - 1));
  assign v_wrap    = h_wrap && (v_q == VW'(V_TOTAL - 1));
  assign h_vis     = (h_q < HW'(H_VISIBLE));
  assign v_vis     = (v_q < VW'(V_VISIBLE));
  assign in_fb     = h_vis && v_vis && (fb_x_q < FXW'(FB_WIDTH)) && (fb_y_q < FYW'(FB_HEIGHT));
  assign hsync_raw = (h_q >= HW'(H_VISIBLE + H_FP)) && (h_q < HW'(H_VISIBLE + H_FP + H_SYNC));
  assign vsync_raw = (v_q >= VW'(V_VISIBLE + V_FP)) && (v_q < VW'(V_VISIBLE + V_FP + V_SYNC));

  always_comb begin
    div_d       = pix_tick ? '0 : div_q + 1'b1;
    h_d         = h_q;
    v_d         = v_q;
    x_sub_d     = x_sub_q;
    fb_x_d      = fb_x_q;
    y_sub_d     = y_sub_q;
    fb_y_d      = fb_y_q;
    line_base_d = line_base_q;

    if (pix_tick) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
    end
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 1'b1;
    end

    // Horizontal replication; fb_x saturates at FB_WIDTH so the rest of the
    // visible line falls into the black border.
    if (h_wrap) begin
      x_sub_d = '0;
      fb_x_d  = '0;
    end else if (pix_tick && h_vis && (fb_x_q < FXW'(FB_WIDTH))) begin
      if (x_sub_q == XSW'(X_SCALE - 1)) begin
        x_sub_d = '0;
        fb_x_d  = fb_x_q + 1'b1;
      end else begin
        x_sub_d = x_sub_q + 1'b1;
      end
    end

    // Vertical replication; line_base tracks fb_y*FB_WIDTH by accumulation.
    if (v_wrap) begin
      y_sub_d     = '0;
      fb_y_d      = '0;
      line_base_d = '0;
    end else if (h_wrap && v_vis) begin
      if (y_sub_q == YSW'(Y_SCALE - 1)) begin
        y_sub_d     = '0;
        fb_y_d      = fb_y_q + 1'b1;
        line_base_d = line_base_q + ADDR_W'(FB_WIDTH);
      end else begin
        y_sub_d = y_sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      x_sub_q     <= '0;
      fb_x_q      <= '0;
      y_sub_q     <= '0;
      fb_y_q      <= '0;
      line_base_q <= '0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_infb_q   <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_vb_q     <= 1'b0;
      s1_fs_q     <= 1'b0;
      rgb_q       <= '0;
      hsync_q     <= SYNC_OFF;
      vsync_q     <= SYNC_OFF;
      vblank_q    <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      div_q       <= div_d;
      h_q         <= h_d;
      v_q         <= v_d;
      x_sub_q     <= x_sub_d;
      fb_x_q      <= fb_x_d;
      y_sub_q     <= y_sub_d;
      fb_y_q      <= fb_y_d;
      line_base_q <= line_base_d;
      // Stage 1: flags of state T, aligned with the RAM read in flight
      s1_hs_q     <= hsync_raw;
      s1_vs_q     <= vsync_raw;
      s1_infb_q   <= in_fb;
      s1_en_q     <= bus.en;
      s1_vb_q     <= !v_vis;
      s1_fs_q     <= (h_q == '0) && (v_q == '0) && (div_q == '0);
      // Stage 2: RAM data for state T arrives now; gate with en/in_fb
      rgb_q       <= (s1_infb_q && s1_en_q) ? bus.fb_pixel : '0;
      hsync_q     <= (s1_hs_q && s1_en_q) ? SYNC_ON : SYNC_OFF;
      vsync_q     <= (s1_vs_q && s1_en_q) ? SYNC_ON : SYNC_OFF;
      vblank_q    <= s1_vb_q;
      fs_q        <= s1_fs_q && s1_en_q;
    end
  end

  assign bus.fb_addr     = in_fb ? (line_base_q + ADDR_W'(fb_x_q)) : '0;
  assign bus.vga_r       = rgb_q[0 +: COLOR_W];
  assign bus.vga_g       = rgb_q[COLOR_W +: COLOR_W];
  assign bus.vga_b       = rgb_q[2*COLOR_W +: COLOR_W];
  assign bus.vga_hsync   = hsync_q;
  assign bus.vga_vsync   = vsync_q;
  assign bus.vblank      = vblank_q;
  assign bus.frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scaled.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scaled
// Description : Directed bench for vga_scaled. Instance A uses the default
//               parameters, B uses CPP=1/X=2/Y=4 with a 320x120 framebuffer,
//               C is a tiny raster so whole frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scaled;

  localparam int SIG_ADDR = 0;
  localparam int SIG_RGB  = 1;
  localparam int SIG_HS   = 2;
  localparam int SIG_VS   = 3;
  localparam int SIG_VB   = 4;
  localparam int SIG_FS   = 5;

  typedef struct {
    int p;      // instance 0=A 1=B 2=C
    int k;      // clocks since reset release
    bit en;     // en driven after the comparison
    int sig;
    int exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   k;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  vga_scaled_if #(.COLOR_W(1), .ADDR_W(16)) if_a ();
  vga_scaled_if #(.COLOR_W(1), .ADDR_W(16)) if_b ();
  vga_scaled_if #(.COLOR_W(1), .ADDR_W(16)) if_c ();

  vga_scaled u_a (.clk(clk), .rst(rst_a), .bus(if_a));

  vga_scaled #(.CLKS_PER_PIXEL(1), .X_SCALE(2), .Y_SCALE(4),
               .FB_WIDTH(320), .FB_HEIGHT(120))
    u_b (.clk(clk), .rst(rst_b), .bus(if_b));

  vga_scaled #(.H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
               .V_VISIBLE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
               .CLKS_PER_PIXEL(1), .X_SCALE(2), .Y_SCALE(4),
               .FB_WIDTH(7), .FB_HEIGHT(3))
    u_c (.clk(clk), .rst(rst_c), .bus(if_c));

  // Behavioural 1-cycle RAMs
  always_ff @(posedge clk) begin
    if_a.fb_pixel <= if_a.fb_addr[2:0];
    if_b.fb_pixel <= if_b.fb_addr[2:0];
    if_c.fb_pixel <= 3'b111;
  end

  function automatic int cur(input int p, input int s);
    logic [15:0] a;
    logic [2:0]  rgb;
    logic        hs, vs, vb, fs;
    a = '0; rgb = '0; hs = 1'b0; vs = 1'b0; vb = 1'b0; fs = 1'b0;
    case (p)
      0: begin a = if_a.fb_addr; rgb = {if_a.vga_b, if_a.vga_g, if_a.vga_r};
               hs = if_a.vga_hsync; vs = if_a.vga_vsync; vb = if_a.vblank; fs = if_a.frame_start; end
      1: begin a = if_b.fb_addr; rgb = {if_b.vga_b, if_b.vga_g, if_b.vga_r};
               hs = if_b.vga_hsync; vs = if_b.vga_vsync; vb = if_b.vblank; fs = if_b.frame_start; end
      default: begin a = if_c.fb_addr; rgb = {if_c.vga_b, if_c.vga_g, if_c.vga_r};
               hs = if_c.vga_hsync; vs = if_c.vga_vsync; vb = if_c.vblank; fs = if_c.frame_start; end
    endcase
    case (s)
      SIG_ADDR: return int'(a);
      SIG_RGB:  return int'(rgb);
      SIG_HS:   return int'(hs);
      SIG_VS:   return int'(vs);
      SIG_VB:   return int'(vb);
      default:  return int'(fs);
    endcase
  endfunction

  function automatic string sname(input int p, input int s);
    string n;
    case (s)
      SIG_ADDR: n = "fb_addr";
      SIG_RGB:  n = "rgb";
      SIG_HS:   n = "hsync";
      SIG_VS:   n = "vsync";
      SIG_VB:   n = "vblank";
      default:  n = "frame_start";
    endcase
    return $sformatf("%s.%s", (p == 0) ? "A" : (p == 1) ? "B" : "C", n);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic set_rst(input int p, input logic v);
    case (p)
      0: rst_a = v;
      1: rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  task automatic set_en(input int p, input logic v);
    case (p)
      0: if_a.en = v;
      1: if_b.en = v;
      default: if_c.en = v;
    endcase
  endtask

  task automatic check_reset(input int p);
    check({sname(p, SIG_ADDR), "_rst"}, cur(p, SIG_ADDR), 0);
    check({sname(p, SIG_RGB),  "_rst"}, cur(p, SIG_RGB),  0);
    check({sname(p, SIG_HS),   "_rst"}, cur(p, SIG_HS),   1);
    check({sname(p, SIG_VS),   "_rst"}, cur(p, SIG_VS),   1);
    check({sname(p, SIG_VB),   "_rst"}, cur(p, SIG_VB),   0);
    check({sname(p, SIG_FS),   "_rst"}, cur(p, SIG_FS),   0);
  endtask

  task automatic add(input int p, input int kk, input bit en, input int s, input int e);
    vec_t v;
    v.p = p; v.k = kk; v.en = en; v.sig = s; v.exp = e;
    vecs.push_back(v);
  endtask

  // Mid-frame reset point, address just before it, and a post-restart probe
  int rst_at[3]     = '{10000, 3500, 1010};
  int rst_addr[3]   = '{492, 470, 15};
  int after_k[3]    = '{6, 3200, 96};
  int after_addr[3] = '{1, 320, 7};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.en = 1'b1; if_b.en = 1'b1; if_c.en = 1'b1;
    k = 0;

    // ---- A: defaults (line 1600 clocks, 6 clocks per fb pixel) ----
    add(0,    0, 1, SIG_ADDR, 0);   add(0,    1, 1, SIG_FS, 0);
    add(0,    2, 1, SIG_FS, 1);     add(0,    3, 1, SIG_FS, 0);
    add(0,    5, 1, SIG_ADDR, 0);   add(0,    6, 1, SIG_ADDR, 1);
    add(0,   12, 1, SIG_ADDR, 2);   add(0,   31, 1, SIG_RGB, 4);
    add(0,   32, 1, SIG_RGB, 5);    add(0,   37, 1, SIG_RGB, 5);
    add(0,   38, 1, SIG_RGB, 6);    add(0, 1272, 1, SIG_ADDR, 212);
    add(0, 1277, 1, SIG_ADDR, 212); add(0, 1278, 1, SIG_ADDR, 0);
    add(0, 1279, 1, SIG_RGB, 4);    add(0, 1280, 1, SIG_RGB, 0);
    add(0, 1313, 1, SIG_HS, 1);     add(0, 1314, 1, SIG_HS, 0);
    add(0, 1505, 1, SIG_HS, 0);     add(0, 1506, 1, SIG_HS, 1);
    add(0, 1600, 1, SIG_ADDR, 0);   add(0, 1606, 1, SIG_ADDR, 1);
    add(0, 2877, 1, SIG_ADDR, 212); add(0, 2914, 1, SIG_HS, 0);
    add(0, 3106, 1, SIG_HS, 1);     add(0, 3200, 1, SIG_ADDR, 0);
    add(0, 4800, 1, SIG_ADDR, 213); add(0, 4806, 1, SIG_ADDR, 214);
    add(0, 6077, 1, SIG_ADDR, 425); add(0, 6078, 1, SIG_ADDR, 0);
    add(0, 6500, 0, SIG_ADDR, 229); add(0, 6501, 0, SIG_RGB, 5);
    add(0, 6502, 0, SIG_RGB, 0);    add(0, 6600, 1, SIG_ADDR, 246);
    add(0, 6601, 1, SIG_RGB, 0);    add(0, 6602, 1, SIG_RGB, 6);
    add(0, 7713, 1, SIG_HS, 1);     add(0, 7714, 1, SIG_HS, 0);
    add(0, 9320, 0, SIG_HS, 0);     add(0, 9321, 0, SIG_HS, 0);
    add(0, 9322, 0, SIG_HS, 1);     add(0, 9420, 1, SIG_HS, 1);
    add(0, 9421, 1, SIG_HS, 1);     add(0, 9422, 1, SIG_HS, 0);
    add(0, 9505, 1, SIG_HS, 0);     add(0, 9506, 1, SIG_HS, 1);
    add(0, 9600, 1, SIG_ADDR, 426);
    // ---- B: CPP=1, X=2, Y=4, 320x120 (line 800 clocks) ----
    add(1,    0, 1, SIG_ADDR, 0);   add(1,    1, 1, SIG_ADDR, 0);
    add(1,    2, 1, SIG_ADDR, 1);   add(1,    2, 1, SIG_FS, 1);
    add(1,    3, 1, SIG_FS, 0);     add(1,    4, 1, SIG_RGB, 1);
    add(1,  639, 1, SIG_ADDR, 319); add(1,  640, 1, SIG_ADDR, 0);
    add(1,  657, 1, SIG_HS, 1);     add(1,  658, 1, SIG_HS, 0);
    add(1,  800, 1, SIG_ADDR, 0);   add(1, 2400, 1, SIG_ADDR, 0);
    add(1, 2402, 1, SIG_ADDR, 1);   add(1, 3200, 1, SIG_ADDR, 320);
    add(1, 3202, 1, SIG_ADDR, 321);
    // ---- C: tiny raster, 24 x 17, frame 408 clocks, border at cols 14-15 ----
    add(2,    0, 1, SIG_ADDR, 0);   add(2,    1, 1, SIG_RGB, 0);
    add(2,    2, 1, SIG_RGB, 7);    add(2,    2, 1, SIG_FS, 1);
    add(2,    3, 1, SIG_FS, 0);     add(2,   13, 1, SIG_ADDR, 6);
    add(2,   14, 1, SIG_ADDR, 0);   add(2,   15, 1, SIG_RGB, 7);
    add(2,   16, 1, SIG_RGB, 0);    add(2,   19, 1, SIG_HS, 1);
    add(2,   20, 1, SIG_HS, 0);     add(2,   22, 1, SIG_HS, 0);
    add(2,   23, 1, SIG_HS, 1);     add(2,   96, 1, SIG_ADDR, 7);
    add(2,  192, 1, SIG_ADDR, 14);  add(2,  277, 1, SIG_ADDR, 20);
    add(2,  288, 1, SIG_ADDR, 0);   add(2,  289, 1, SIG_VB, 0);
    add(2,  290, 1, SIG_VB, 1);     add(2,  290, 1, SIG_RGB, 0);
    add(2,  313, 1, SIG_VS, 1);     add(2,  314, 1, SIG_VS, 0);
    add(2,  361, 1, SIG_VS, 0);     add(2,  362, 1, SIG_VS, 1);
    add(2,  409, 1, SIG_VB, 1);     add(2,  409, 1, SIG_FS, 0);
    add(2,  410, 1, SIG_VB, 0);     add(2,  410, 1, SIG_FS, 1);
    add(2,  720, 0, SIG_VS, 1);     add(2,  721, 0, SIG_VS, 1);
    add(2,  722, 0, SIG_VS, 1);     add(2,  730, 0, SIG_VB, 1);
    add(2,  740, 1, SIG_VS, 1);     add(2,  741, 1, SIG_VS, 1);
    add(2,  742, 1, SIG_VS, 0);     add(2,  818, 1, SIG_FS, 1);

    repeat (3) @(negedge clk);
    for (int p = 0; p < 3; p++) check_reset(p);

    for (int p = 0; p < 3; p++) begin
      set_rst(p, 1'b0);
      k = 0;
      foreach (vecs[i]) begin
        if (vecs[i].p == p) begin
          while (k < vecs[i].k) tick();
          check(sname(p, vecs[i].sig), cur(p, vecs[i].sig), vecs[i].exp);
          set_en(p, vecs[i].en);
        end
      end

      // Single-cycle reset in the middle of a visible line
      while (k < rst_at[p]) tick();
      check({sname(p, SIG_ADDR), "_pre_rst"}, cur(p, SIG_ADDR), rst_addr[p]);
      set_rst(p, 1'b1);
      tick();
      check_reset(p);
      set_rst(p, 1'b0);
      k = 0;
      tick();
      check({sname(p, SIG_FS), "_restart1"}, cur(p, SIG_FS), 0);
      tick();
      check({sname(p, SIG_FS), "_restart2"}, cur(p, SIG_FS), 1);
      tick();
      check({sname(p, SIG_FS), "_restart3"}, cur(p, SIG_FS), 0);
      while (k < after_k[p]) tick();
      check({sname(p, SIG_ADDR), "_restart"}, cur(p, SIG_ADDR), after_addr[p]);
      set_rst(p, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scaled.md
# vga_scaled

Parametrised raster generator with integer scaling. It reads a low-resolution framebuffer through a 1-cycle synchronous read port. Each framebuffer pixel is replicated X_SCALE times horizontally and Y_SCALE times vertically, so lines repeat correctly. The block drives VGA RGB and sync pins and sits between the framebuffer RAM and the board's VGA connector. It also exports frame and vblank strobes so the CPU can time framebuffer updates.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_VISIBLE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- CLKS_PER_PIXEL, 2, clk cycles per pixel (≥1)
- X_SCALE / Y_SCALE, 3 / 3, replication factors (≥1)
- FB_WIDTH / FB_HEIGHT, 213 / 160; requires FB_WIDTH*X_SCALE ≤ H_VISIBLE and FB_HEIGHT*Y_SCALE ≤ V_VISIBLE
- COLOR_W, 1, bits per colour channel
- ADDR_W, 16, framebuffer address width
- SYNC_ACTIVE_LOW, 1, sync polarity

Ports:
- clk  in  1  system clock (50 MHz nominal)
- rst  in  1  reset, synchronous, active-high
- en  in  1  output enable
- fb_addr  out  ADDR_W  framebuffer read address
- fb_pixel  in  3*COLOR_W  {b,g,r}; valid one cycle after fb_addr
- vga_r / vga_g / vga_b  out  COLOR_W each  colour outputs
- vga_hsync / vga_vsync  out  1 each  sync outputs
- vblank  out  1  high while the output line is ≥ V_VISIBLE
- frame_start  out  1  one-cycle pulse at the first clock of output pixel (0,0)

## Operation
Counters (all reset to 0):
- div counts 0..CLKS_PER_PIXEL-1. pix_tick = (div == CLKS_PER_PIXEL-1).
- h counts 0..H_TOTAL-1 on pix_tick.
- v counts 0..V_TOTAL-1 when h wraps.

Addressing state:
- fb_x/x_sub: reset at every h wrap. While h < H_VISIBLE and fb_x < FB_WIDTH, x_sub advances on pix_tick and wraps at X_SCALE-1; on that wrap fb_x increments.
- fb_y/y_sub/line_base: reset at every v wrap. At each h wrap where v < V_VISIBLE, y_sub advances and wraps at Y_SCALE-1; on that wrap fb_y increments and line_base += FB_WIDTH.
- No multipliers are used.

Address output:
- in_fb = (h < H_VISIBLE) & (v < V_VISIBLE) & (fb_x < FB_WIDTH) & (fb_y < FB_HEIGHT).
- fb_addr = in_fb ? line_base + fb_x : 0.

Derived signals:
- Visible-but-not-in_fb pixels form the border and are black (e.g. column 639 with the defaults).
- hsync_raw is active for H_VISIBLE+H_FP ≤ h < H_VISIBLE+H_FP+H_SYNC.
- vsync_raw uses the same rule with the V parameters.

Enable:
- en is sampled alongside the counters.
- When en is low, RGB is 0, both syncs are inactive, and frame_start is 0.
- Counters keep running while en is low.
- vblank is not gated by en.

## Timing
Pipeline, with counter state at cycle T:
- fb_addr is valid in cycle T.
- fb_pixel is sampled at the end of T+1.
- vga_*, vblank and frame_start reflect state T during cycle T+2.
- Sync, in_fb and en flags are delayed two registers so all outputs stay aligned.

Reset values (from the cycle after rst is sampled high):
- vga_r/g/b = 0.
- Syncs inactive: 1 if SYNC_ACTIVE_LOW, else 0.
- vblank = 0, frame_start = 0, fb_addr = 0.

Reset mid-frame:
- All counters and pipeline registers clear in one cycle.
- The raster restarts at (0,0).
- The first frame_start occurs 2 cycles after rst deasserts.

Frame timing with defaults:
- Line = 1600 clocks.
- Frame = 525 lines = 840000 clocks.
- The hsync low pulse is 192 clocks.

Simultaneous wraps:
- An h wrap takes priority over x_sub/fb_x advance; both clear.
- A v wrap takes priority over y_sub/fb_y/line_base advance; all clear.

## Test plan
- Reset with defaults -> outputs take the reset values above. The first frame_start arrives 2 clocks after rst falls. The hsync edge after that pulse falls at clock 1312 and is low for 192 clocks, then repeats every 1600. vsync is low for lines 490–491. frame_start period is 840000.
- Line 0 addresses -> fb_addr holds 0 for 6 clocks, then 1 for 6 clocks, …, 212 through clock 1277. fb_addr is 0 for the rest of the line.
- Line replication -> lines 0, 1 and 2 produce identical address sequences. Line 3 starts at 213. Line 477 starts at 159*213 = 33867. Lines 480 and above keep fb_addr = 0, and vblank is high at the outputs two clocks later.
- Behavioural 1-cycle RAM with pixel = addr[2:0] -> vga_{b,g,r} equals the pixel for addr 5 (101) exactly 2 clocks after fb_addr = 5. Column 639 is black.
- en dropped mid-line for 100 clocks -> RGB is 0 and syncs are inactive from 2 clocks after the drop until 2 clocks after en returns. Counter alignment is unchanged, so the next hsync falls at the same clock as with en held high.
- rst pulsed for 1 cycle at line 200, pixel 300 -> the next cycle shows all reset values. fb_addr restarts at 0. frame_start follows 2 clocks after release. Repeat with CLKS_PER_PIXEL=1, X_SCALE=2, Y_SCALE=4, FB_WIDTH=320, FB_HEIGHT=120, and check line 4 starts at address 320.
